// File: rtl/pc_pkg.sv
// Shared types and default sizes for the stacked program counter.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_RET,
    PC_CALL,
    PC_LOAD,
    PC_OFFSET,
    PC_INC
  } pc_op_e;

  localparam int unsigned DefPcWidth     = 16;
  localparam int unsigned DefOffsetWidth = 9;
  localparam int unsigned DefStackDepth  = 8;

endpackage

// File: rtl/return_stack.sv
// Return-address LIFO: at most one push or one pop per cycle, push wins.
module return_stack
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = DefPcWidth,
  parameter int unsigned DEPTH = DefStackDepth,
  localparam int unsigned CW   = $clog2(DEPTH + 1),
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_push_data,
  output logic [WIDTH-1:0] o_top_data,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_count;
  logic             r_full;
  logic             r_empty;
  logic [CW-1:0]    w_count_d;
  logic [CW-1:0]    w_count_m1;
  logic [PW-1:0]    w_wr_idx;
  logic [PW-1:0]    w_rd_idx;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push  = i_push && !r_full;
  assign w_do_pop   = i_pop && !r_empty && !i_push;
  assign w_count_m1 = r_count - CW'(1);
  assign w_wr_idx   = r_count[PW-1:0];
  assign w_rd_idx   = w_count_m1[PW-1:0];

  always_comb begin
    w_count_d = r_count;
    if (w_do_push) begin
      w_count_d = r_count + CW'(1);
    end else if (w_do_pop) begin
      w_count_d = w_count_m1;
    end
  end

  // Full/empty are registered so the top can expose them straight from flops.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_count <= w_count_d;
      r_full  <= (w_count_d == CW'(DEPTH));
      r_empty <= (w_count_d == '0);
    end
  end

  // Storage is not reset; discarding entries only needs the count cleared.
  always_ff @(posedge Clock) begin
    if (w_do_push) begin
      r_mem[w_wr_idx] <= i_push_data;
    end
  end

  assign o_top_data = r_mem[w_rd_idx];
  assign o_count    = r_count;
  assign o_full     = r_full;
  assign o_empty    = r_empty;

endmodule

// File: rtl/stacked_program_counter.sv
// Program counter with absolute/relative jumps and a call/return stack.
module stacked_program_counter
  import pc_pkg::*;
#(
  parameter int unsigned PC_WIDTH     = DefPcWidth,
  parameter int unsigned OFFSET_WIDTH = DefOffsetWidth,
  parameter int unsigned STACK_DEPTH  = DefStackDepth,
  parameter int unsigned RESET_VECTOR = 0,
  localparam int unsigned CW          = $clog2(STACK_DEPTH + 1)
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [PC_WIDTH-1:0]     LoadValue,
  input  logic                    LoadEnable,
  input  logic [OFFSET_WIDTH-1:0] Offset,
  input  logic                    OffsetEnable,
  input  logic                    Call,
  input  logic                    Return,
  input  logic                    Stall,
  input  logic                    ClearError,
  output logic [PC_WIDTH-1:0]     CounterValue,
  output logic [CW-1:0]           StackCount,
  output logic                    StackFull,
  output logic                    StackEmpty,
  output logic                    StackError
);

  pc_op_e              w_op;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pc_d;
  logic [PC_WIDTH-1:0] w_pc_inc;
  logic [PC_WIDTH-1:0] w_top;
  logic                r_err;
  logic                w_err_d;
  logic                w_err_set;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;

  always_comb begin
    w_op = PC_INC;
    if (Stall) begin
      w_op = PC_HOLD;
    end else if (Return) begin
      w_op = PC_RET;
    end else if (Call) begin
      w_op = PC_CALL;
    end else if (LoadEnable) begin
      w_op = PC_LOAD;
    end else if (OffsetEnable) begin
      w_op = PC_OFFSET;
    end
  end

  assign w_pc_inc = r_pc + PC_WIDTH'(1);
  assign w_push   = (w_op == PC_CALL) && !w_full;
  assign w_pop    = (w_op == PC_RET) && !w_empty;

  always_comb begin
    w_pc_d    = r_pc;
    w_err_set = 1'b0;
    unique case (w_op)
      PC_HOLD:   w_pc_d = r_pc;
      PC_RET: begin
        w_pc_d    = w_empty ? w_pc_inc : w_top;
        w_err_set = w_empty;
      end
      PC_CALL: begin
        w_pc_d    = w_full ? w_pc_inc : LoadValue;
        w_err_set = w_full;
      end
      PC_LOAD:   w_pc_d = LoadValue;
      PC_OFFSET: w_pc_d = r_pc + PC_WIDTH'($signed(Offset));
      PC_INC:    w_pc_d = w_pc_inc;
      default:   w_pc_d = r_pc;
    endcase
    // A fresh overflow/underflow beats a simultaneous clear.
    w_err_d = (w_op == PC_HOLD) ? r_err : (w_err_set || (r_err && !ClearError));
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_pc  <= PC_WIDTH'(RESET_VECTOR);
      r_err <= 1'b0;
    end else begin
      r_pc  <= w_pc_d;
      r_err <= w_err_d;
    end
  end

  return_stack #(
    .WIDTH (PC_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_return_stack (
    .Clock       (Clock),
    .Reset       (Reset),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_push_data (w_pc_inc),
    .o_top_data  (w_top),
    .o_count     (StackCount),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  assign CounterValue = r_pc;
  assign StackFull    = w_full;
  assign StackEmpty   = w_empty;
  assign StackError   = r_err;

endmodule

// File: tb/tb_stacked_program_counter.sv
// Directed scenarios plus a randomized run against a queue-based reference model.
module tb_stacked_program_counter;

  localparam int SD = 8;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] LoadValue;
  logic        LoadEnable;
  logic [8:0]  Offset;
  logic        OffsetEnable;
  logic        Call;
  logic        Return;
  logic        Stall;
  logic        ClearError;
  logic [15:0] CounterValue;
  logic [3:0]  StackCount;
  logic        StackFull;
  logic        StackEmpty;
  logic        StackError;

  int n_checks = 0;
  int n_fail   = 0;

  stacked_program_counter dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .LoadValue    (LoadValue),
    .LoadEnable   (LoadEnable),
    .Offset       (Offset),
    .OffsetEnable (OffsetEnable),
    .Call         (Call),
    .Return       (Return),
    .Stall        (Stall),
    .ClearError   (ClearError),
    .CounterValue (CounterValue),
    .StackCount   (StackCount),
    .StackFull    (StackFull),
    .StackEmpty   (StackEmpty),
    .StackError   (StackError)
  );

  always #5 Clock = ~Clock;

  task automatic idle();
    LoadValue = '0; LoadEnable = 0; Offset = '0; OffsetEnable = 0;
    Call = 0; Return = 0; Stall = 0; ClearError = 0;
  endtask

  // Inputs change on the falling edge; outputs are read on the next falling edge.
  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic test_reset();
    Reset = 1; idle();
    repeat (2) @(negedge Clock);
    n_checks++;
    if (CounterValue !== 16'h0000) begin
      n_fail++; $display("FAIL reset_pc got=%h want=0000", CounterValue);
    end
    n_checks++;
    if (StackEmpty !== 1'b1 || StackFull !== 1'b0 || StackCount !== 4'd0 || StackError !== 1'b0)
      begin
      n_fail++;
      $display("FAIL reset_flags got e=%b f=%b c=%0d err=%b want e=1 f=0 c=0 err=0",
               StackEmpty, StackFull, StackCount, StackError);
    end
    Reset = 0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_checks++;
      if (CounterValue !== 16'(i)) begin
        n_fail++; $display("FAIL idle_inc got=%h want=%h", CounterValue, 16'(i));
      end
    end
  endtask

  task automatic test_offset();
    LoadValue = 16'h0010; LoadEnable = 1; tick(); LoadEnable = 0;
    n_checks++;
    if (CounterValue !== 16'h0010) begin
      n_fail++; $display("FAIL load got=%h want=0010", CounterValue);
    end
    Offset = 9'h1FB; OffsetEnable = 1; tick();
    n_checks++;
    if (CounterValue !== 16'h000B) begin
      n_fail++; $display("FAIL offset_neg got=%h want=000b", CounterValue);
    end
    Offset = 9'h0FF; tick(); OffsetEnable = 0;
    n_checks++;
    if (CounterValue !== 16'h010A) begin
      n_fail++; $display("FAIL offset_pos got=%h want=010a", CounterValue);
    end
    LoadValue = 16'hFFFF; LoadEnable = 1; tick(); LoadEnable = 0; tick();
    n_checks++;
    if (CounterValue !== 16'h0000) begin
      n_fail++; $display("FAIL inc_wrap got=%h want=0000", CounterValue);
    end
    LoadValue = 16'hFFFE; LoadEnable = 1; tick(); LoadEnable = 0;
    Offset = 9'd5; OffsetEnable = 1; tick(); OffsetEnable = 0;
    n_checks++;
    if (CounterValue !== 16'h0003) begin
      n_fail++; $display("FAIL offset_wrap got=%h want=0003", CounterValue);
    end
  endtask

  task automatic test_call_return();
    LoadValue = 16'h0020; LoadEnable = 1; tick(); LoadEnable = 0;
    LoadValue = 16'h0100; Call = 1; tick(); Call = 0;
    n_checks++;
    if (CounterValue !== 16'h0100 || StackCount !== 4'd1) begin
      n_fail++; $display("FAIL call got pc=%h cnt=%0d want pc=0100 cnt=1", CounterValue, StackCount);
    end
    tick(); tick();
    Return = 1; tick(); Return = 0;
    n_checks++;
    if (CounterValue !== 16'h0021 || StackEmpty !== 1'b1) begin
      n_fail++; $display("FAIL return got pc=%h e=%b want pc=0021 e=1", CounterValue, StackEmpty);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] exp_ret [SD];
    logic [15:0] exp_pc;
    exp_pc = CounterValue;
    Call = 1;
    for (int i = 0; i < SD; i++) begin
      LoadValue  = 16'h1000 + 16'(i * 16);
      exp_ret[i] = exp_pc + 16'd1;
      tick();
      exp_pc = LoadValue;
    end
    n_checks++;
    if (StackFull !== 1'b1 || StackCount !== 4'd8 || CounterValue !== exp_pc) begin
      n_fail++;
      $display("FAIL nested_calls got f=%b c=%0d pc=%h want f=1 c=8 pc=%h",
               StackFull, StackCount, CounterValue, exp_pc);
    end
    LoadValue = 16'h5555; tick(); Call = 0;
    n_checks++;
    if (StackError !== 1'b1 || CounterValue !== exp_pc + 16'd1 || StackCount !== 4'd8) begin
      n_fail++;
      $display("FAIL overflow got err=%b pc=%h c=%0d want err=1 pc=%h c=8",
               StackError, CounterValue, StackCount, exp_pc + 16'd1);
    end
    Return = 1;
    for (int i = SD - 1; i >= 0; i--) begin
      tick();
      n_checks++;
      if (CounterValue !== exp_ret[i]) begin
        n_fail++; $display("FAIL unwind_%0d got=%h want=%h", i, CounterValue, exp_ret[i]);
      end
    end
    Return = 0;
    n_checks++;
    if (StackEmpty !== 1'b1 || StackError !== 1'b1) begin
      n_fail++; $display("FAIL unwind_end got e=%b err=%b want e=1 err=1", StackEmpty, StackError);
    end
  endtask

  task automatic test_underflow_stall();
    logic [15:0] p;
    ClearError = 1; tick(); ClearError = 0;
    n_checks++;
    if (StackError !== 1'b0) begin
      n_fail++; $display("FAIL clear_error got=%b want=0", StackError);
    end
    p = CounterValue;
    Return = 1; tick(); Return = 0;
    n_checks++;
    if (StackError !== 1'b1 || CounterValue !== p + 16'd1 || StackCount !== 4'd0) begin
      n_fail++;
      $display("FAIL underflow got err=%b pc=%h c=%0d want err=1 pc=%h c=0",
               StackError, CounterValue, StackCount, p + 16'd1);
    end
    p = CounterValue;
    LoadValue = 16'h0400; Call = 1; tick(); Call = 0;
    Stall = 1; Call = 1; LoadEnable = 1; ClearError = 1; LoadValue = 16'h7777;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (CounterValue !== 16'h0400 || StackCount !== 4'd1 || StackError !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_%0d got pc=%h c=%0d err=%b want pc=0400 c=1 err=1",
                 i, CounterValue, StackCount, StackError);
      end
    end
    idle();
    Return = 1; ClearError = 1; tick();
    n_checks++;
    if (CounterValue !== p + 16'd1 || StackError !== 1'b0) begin
      n_fail++;
      $display("FAIL ret_clear got pc=%h err=%b want pc=%h err=0", CounterValue, StackError, p + 16'd1);
    end
    tick(); idle();
    n_checks++;
    if (StackError !== 1'b1) begin
      n_fail++; $display("FAIL err_beats_clear got=%b want=1", StackError);
    end
  endtask

  task automatic test_call_return_conflict();
    logic [15:0] p;
    ClearError = 1; tick(); ClearError = 0;
    p = CounterValue;
    LoadValue = 16'h0800; Call = 1; tick();
    LoadValue = 16'h0900; Return = 1; tick(); idle();
    n_checks++;
    if (CounterValue !== p + 16'd1 || StackCount !== 4'd0 || StackError !== 1'b0) begin
      n_fail++;
      $display("FAIL ret_over_call got pc=%h c=%0d err=%b want pc=%h c=0 err=0",
               CounterValue, StackCount, StackError, p + 16'd1);
    end
  endtask

  task automatic test_async_reset();
    Call = 1;
    for (int i = 0; i < 3; i++) begin
      LoadValue = 16'h0A00 + 16'(i); tick();
    end
    Call = 0;
    n_checks++;
    if (StackCount !== 4'd3) begin
      n_fail++; $display("FAIL pre_reset_count got=%0d want=3", StackCount);
    end
    @(posedge Clock); #2 Reset = 1; #1;
    n_checks++;
    if (CounterValue !== 16'h0000 || StackCount !== 4'd0 || StackEmpty !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset got pc=%h c=%0d e=%b want pc=0000 c=0 e=1",
               CounterValue, StackCount, StackEmpty);
    end
    @(negedge Clock); Reset = 0;
    tick();
    n_checks++;
    if (CounterValue !== 16'h0001) begin
      n_fail++; $display("FAIL first_after_reset got=%h want=0001", CounterValue);
    end
  endtask

  task automatic test_random();
    logic [15:0] m_pc;
    logic [15:0] m_q[$];
    logic        m_err;
    logic        set;
    Reset = 1; idle(); @(negedge Clock); Reset = 0;
    m_pc = 16'h0000; m_q = {}; m_err = 0;
    for (int n = 0; n < 600; n++) begin
      Stall        = ($urandom_range(0, 7) == 0);
      Return       = ($urandom_range(0, 3) == 0);
      Call         = ($urandom_range(0, 2) == 0);
      LoadEnable   = ($urandom_range(0, 5) == 0);
      OffsetEnable = ($urandom_range(0, 3) == 0);
      ClearError   = ($urandom_range(0, 5) == 0);
      LoadValue    = 16'($urandom);
      Offset       = 9'($urandom);
      @(posedge Clock);
      if (!Stall) begin
        set = 0;
        if (Return) begin
          if (m_q.size() == 0) begin set = 1; m_pc = m_pc + 16'd1; end
          else m_pc = m_q.pop_back();
        end else if (Call) begin
          if (m_q.size() == SD) begin set = 1; m_pc = m_pc + 16'd1; end
          else begin m_q.push_back(m_pc + 16'd1); m_pc = LoadValue; end
        end else if (LoadEnable) m_pc = LoadValue;
        else if (OffsetEnable) m_pc = 16'(int'(m_pc) + int'($signed(Offset)));
        else m_pc = m_pc + 16'd1;
        m_err = set || (m_err && !ClearError);
      end
      @(negedge Clock);
      n_checks++;
      if (CounterValue !== m_pc || StackCount !== 4'(m_q.size()) || StackError !== m_err ||
          StackFull !== (m_q.size() == SD) || StackEmpty !== (m_q.size() == 0)) begin
        n_fail++;
        $display("FAIL random_%0d got pc=%h c=%0d err=%b f=%b e=%b want pc=%h c=%0d err=%b",
                 n, CounterValue, StackCount, StackError, StackFull, StackEmpty,
                 m_pc, m_q.size(), m_err);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_offset();
    test_call_return();
    test_overflow();
    test_underflow_stall();
    test_call_return_conflict();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
